// File: rtl/lemmings_pkg.sv
// Shared state encoding and transition rules for the lemmings walker family.
// Later variants reuse the 3-bit encoding and the next-state helper.
package lemmings_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      WALK_L = 3'd0,
      WALK_R = 3'd1,
      FALL_L = 3'd2,
      FALL_R = 3'd3,
      DIG_L  = 3'd4,
      DIG_R  = 3'd5,
      SPLAT  = 3'd6
   } lem_state_t;

   // Walking priority: no ground beats dig, dig beats bumps. A simultaneous
   // left+right bump counts as a bump on the side being walked toward.
   function automatic lem_state_t lem_next(input lem_state_t s,
                                           input logic bl,
                                           input logic br,
                                           input logic gnd,
                                           input logic dg,
                                           input logic fatal);
      lem_state_t n;
      n = s;
      case (s)
         WALK_L: begin
            if (!gnd)     n = FALL_L;
            else if (dg)  n = DIG_L;
            else if (bl)  n = WALK_R;
            else          n = WALK_L;
         end
         WALK_R: begin
            if (!gnd)     n = FALL_R;
            else if (dg)  n = DIG_R;
            else if (br)  n = WALK_L;
            else          n = WALK_R;
         end
         FALL_L:  n = gnd ? (fatal ? SPLAT : WALK_L) : FALL_L;
         FALL_R:  n = gnd ? (fatal ? SPLAT : WALK_R) : FALL_R;
         DIG_L:   n = gnd ? DIG_L : FALL_L;
         DIG_R:   n = gnd ? DIG_R : FALL_R;
         SPLAT:   n = SPLAT;
         default: n = WALK_L;
      endcase
      return n;
   endfunction

   function automatic logic lem_is_fall(input lem_state_t s);
      return (s == FALL_L) || (s == FALL_R);
   endfunction

   function automatic logic lem_is_dig(input lem_state_t s);
      return (s == DIG_L) || (s == DIG_R);
   endfunction

endpackage

// File: rtl/lemmings_fsm_sat_counter.sv
// Saturating up-counter: clr wins over inc, and q sticks at LIMIT.
module sat_counter #(
   parameter int WIDTH = 5,
   parameter int LIMIT = 21
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(LIMIT);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != MAX_Q)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/lemmings_fsm.sv
// Moore lemming walker: walk, fall, dig, splat, with a saturating fall timer.
// Every output is a flop loaded from the next state, so all outputs are glitch-free.
module lemmings_fsm
   import lemmings_pkg::*;
#(
   parameter int FALL_LIMIT = 20,
   parameter int CNT_W      = 5
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             bump_left,
   input  logic             bump_right,
   input  logic             ground,
   input  logic             dig,
   output logic             walk_left,
   output logic             walk_right,
   output logic             aaah,
   output logic             digging,
   output logic             splat,
   output logic [CNT_W-1:0] fall_cnt
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(FALL_LIMIT);

   generate
      if ((2 ** CNT_W) - 1 < FALL_LIMIT + 1) begin : g_bad_width
         $error("lemmings_fsm: CNT_W too small to hold FALL_LIMIT+1");
      end
   endgenerate

   lem_state_t state;
   lem_state_t state_nxt;
   logic       fatal;
   logic       cnt_inc;
   logic       cnt_clr;

   assign fatal     = (fall_cnt > LIMIT_C);
   assign state_nxt = lem_next(state, bump_left, bump_right, ground, dig, fatal);

   // Any live state with no ground underneath lands in (or stays in) a fall
   // state on this edge, so the counter tracks the cycles spent falling.
   assign cnt_inc = !ground && (state != SPLAT);
   assign cnt_clr = !cnt_inc;

   sat_counter #(
      .WIDTH (CNT_W),
      .LIMIT (FALL_LIMIT + 1)
   ) u_fall_cnt (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .q       (fall_cnt)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= WALK_L;
         walk_left  <= 1'b1;
         walk_right <= 1'b0;
         aaah       <= 1'b0;
         digging    <= 1'b0;
         splat      <= 1'b0;
      end else begin
         state      <= state_nxt;
         walk_left  <= (state_nxt == WALK_L);
         walk_right <= (state_nxt == WALK_R);
         aaah       <= lem_is_fall(state_nxt);
         digging    <= lem_is_dig(state_nxt);
         splat      <= (state_nxt == SPLAT);
      end
   end

endmodule

// File: tb/tb_lemmings_fsm.sv
// Scenario bench for lemmings_fsm: default instance plus a FALL_LIMIT=4 instance.
module tb_lemmings_fsm;

   logic       sys_clk;
   logic       sys_rst;
   logic       bump_left;
   logic       bump_right;
   logic       ground;
   logic       dig;

   logic       walk_left, walk_right, aaah, digging, splat;
   logic [4:0] fall_cnt;
   logic       wl2, wr2, aaah2, dig2, splat2;
   logic [2:0] fall_cnt2;

   int total;
   int bad;
   logic [9:0] exp_q[$];
   logic [9:0] e;

   wire [9:0] obs1 = {walk_left, walk_right, aaah, digging, splat, fall_cnt};
   wire [9:0] obs2 = {wl2, wr2, aaah2, dig2, splat2, 2'b00, fall_cnt2};

   lemmings_fsm dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging),
      .splat      (splat),
      .fall_cnt   (fall_cnt)
   );

   lemmings_fsm #(.FALL_LIMIT(4), .CNT_W(3)) dut_sat (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (wl2),
      .walk_right (wr2),
      .aaah       (aaah2),
      .digging    (dig2),
      .splat      (splat2),
      .fall_cnt   (fall_cnt2)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1);
   end

   function automatic logic [9:0] pk(input logic wl, input logic wr, input logic a,
                                     input logic dg, input logic sp, input int c);
      return {wl, wr, a, dg, sp, 5'(c)};
   endfunction

   task automatic tick(input logic g, input logic bl, input logic br, input logic d);
      ground     = g;
      bump_left  = bl;
      bump_right = br;
      dig        = d;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      ground = 1'b1; bump_left = 1'b0; bump_right = 1'b0; dig = 1'b0;
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      ground = 1'b1; bump_left = 1'b0; bump_right = 1'b0; dig = 1'b0;
      sys_rst = 1'b1;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL reset_async: got %b want %b", obs1, e); end
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      tick(1, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL reset_idle: got %b want %b", obs1, e); end
   endtask

   task automatic test_bumps();
      logic bl_t[5] = '{1, 1, 0, 1, 0};
      logic br_t[5] = '{0, 1, 1, 0, 1};
      logic [9:0] ex_t[5];
      do_reset();
      ex_t[0] = pk(0, 1, 0, 0, 0, 0);
      ex_t[1] = pk(1, 0, 0, 0, 0, 0);
      ex_t[2] = pk(1, 0, 0, 0, 0, 0);
      ex_t[3] = pk(0, 1, 0, 0, 0, 0);
      ex_t[4] = pk(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(ex_t[i]);
         tick(1, bl_t[i], br_t[i], 0);
         e = exp_q.pop_front();
         total++;
         if (obs1 !== e) begin bad++; $display("FAIL bumps[%0d]: got %b want %b", i, obs1, e); end
      end
   endtask

   task automatic test_survive();
      do_reset();
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      tick(1, 1, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         exp_q.push_back(pk(0, 0, 1, 0, 0, k));
         tick(0, 0, 0, 0);
      end
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      tick(1, 0, 0, 0);
      for (int k = 0; k < 22; k++) begin
         e = exp_q.pop_front();
         total++;
         if (k == 21 && obs1 !== e) begin bad++; $display("FAIL survive_land: got %b want %b", obs1, e); end
         else if (k != 21) total--;
      end
   endtask

   task automatic test_survive_steps();
      do_reset();
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      tick(1, 1, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL survive_start: got %b want %b", obs1, e); end
      for (int k = 1; k <= 20; k++) begin
         exp_q.push_back(pk(0, 0, 1, 0, 0, k));
         tick(0, 1, 1, 1);
         e = exp_q.pop_front();
         total++;
         if (obs1 !== e) begin bad++; $display("FAIL survive_fall[%0d]: got %b want %b", k, obs1, e); end
      end
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      tick(1, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL survive_walk: got %b want %b", obs1, e); end
   endtask

   task automatic test_fatal();
      for (int k = 1; k <= 21; k++) begin
         exp_q.push_back(pk(0, 0, 1, 0, 0, k));
         tick(0, 0, 0, 0);
         e = exp_q.pop_front();
         total++;
         if (obs1 !== e) begin bad++; $display("FAIL fatal_fall[%0d]: got %b want %b", k, obs1, e); end
      end
      exp_q.push_back(pk(0, 0, 0, 0, 1, 0));
      tick(1, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL fatal_splat: got %b want %b", obs1, e); end
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(pk(0, 0, 0, 0, 1, 0));
         tick(i[0], 1'b1, i[1], ~i[0]);
         e = exp_q.pop_front();
         total++;
         if (obs1 !== e) begin bad++; $display("FAIL splat_hold[%0d]: got %b want %b", i, obs1, e); end
      end
      ground = 1'b0;
      sys_rst = 1'b1;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL splat_reset: got %b want %b", obs1, e); end
      ground = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   task automatic test_dig();
      logic g_t[9]  = '{1, 1, 0, 0, 0, 1, 1, 0, 1};
      logic d_t[9]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
      logic [9:0] ex_t[9];
      do_reset();
      ex_t[0] = pk(0, 0, 0, 1, 0, 0);
      ex_t[1] = pk(0, 0, 0, 1, 0, 0);
      ex_t[2] = pk(0, 0, 1, 0, 0, 1);
      ex_t[3] = pk(0, 0, 1, 0, 0, 2);
      ex_t[4] = pk(0, 0, 1, 0, 0, 3);
      ex_t[5] = pk(1, 0, 0, 0, 0, 0);
      ex_t[6] = pk(1, 0, 0, 0, 0, 0);
      ex_t[7] = pk(0, 0, 1, 0, 0, 1);
      ex_t[8] = pk(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(ex_t[i]);
         tick(g_t[i], (i == 0), 1'b0, d_t[i]);
         e = exp_q.pop_front();
         total++;
         if (obs1 !== e) begin bad++; $display("FAIL dig[%0d]: got %b want %b", i, obs1, e); end
      end
      exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
      tick(1, 0, 0, 1);
      sys_rst = 1'b1;
      #1;
      e = exp_q.pop_front();
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      total++;
      if (e !== pk(0, 0, 0, 1, 0, 0) || obs1 !== exp_q[0]) begin
         bad++; $display("FAIL dig_reset: got %b want %b", obs1, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   task automatic test_saturation();
      int c;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         c = (k < 5) ? k : 5;
         exp_q.push_back(pk(0, 0, 1, 0, 0, c));
         tick(0, 0, 0, 0);
         e = exp_q.pop_front();
         total++;
         if (obs2 !== e) begin bad++; $display("FAIL sat_fall[%0d]: got %b want %b", k, obs2, e); end
      end
      exp_q.push_back(pk(0, 0, 0, 0, 1, 0));
      tick(1, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs2 !== e) begin bad++; $display("FAIL sat_splat: got %b want %b", obs2, e); end
   endtask

   task automatic test_async_reset();
      do_reset();
      tick(1, 1, 0, 0);
      for (int k = 1; k <= 7; k++) tick(0, 0, 0, 0);
      exp_q.push_back(pk(0, 0, 1, 0, 0, 7));
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL async_pre: got %b want %b", obs1, e); end
      #3;
      sys_rst = 1'b1;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL async_reset: got %b want %b", obs1, e); end
      ground = 1'b1;
      #2;
      sys_rst = 1'b0;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      tick(1, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL async_resume: got %b want %b", obs1, e); end
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      tick(1, 1, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL async_resume_bump: got %b want %b", obs1, e); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_bumps();
      test_survive_steps();
      test_fatal();
      test_dig();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
